// File: rtl/div_hilo.sv
`default_nettype none
// ============================================================================
// div_hilo : 32-bit restoring radix-2 divider that produces the HI/LO pair
//            (HI = remainder, LO = quotient) for DIV / DIVU.
// Optional : DIV_ZERO_EARLY_EN - a zero divisor skips RUN/FIX and writes
//            after two cycles instead of thirty-four.
// Revision : 1.0
// ============================================================================
module div_hilo (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_div,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        flush,
    output logic        busy,
    output logic        hl_write_enable,
    output logic [63:0] hl_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvsr_q, dvsr_d;
    logic [31:0] dend_q, dend_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic        busy_q, busy_d;
    logic        we_q, we_d;
    logic [63:0] hl_q, hl_d;

    logic [31:0] w_dend_mag;
    logic [31:0] w_dvsr_mag;
    logic [32:0] w_shifted;
    logic        w_ge;
    logic [31:0] w_rem_step;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;
    logic        w_dvsr_zero;
    logic [63:0] w_zero_result;

    assign w_dend_mag = (signed_div && dividend[31]) ? -dividend : dividend;
    assign w_dvsr_mag = (signed_div && divisor[31])  ? -divisor  : divisor;

    // When the trial subtraction succeeds the difference is below the divisor,
    // so the low 32 bits of the wrapped subtraction are the exact remainder.
    assign w_shifted  = {rem_q, quo_q[31]};
    assign w_ge       = (w_shifted >= {1'b0, dvsr_q});
    assign w_rem_step = w_ge ? (w_shifted[31:0] - dvsr_q) : w_shifted[31:0];

    assign w_quo_fix     = neg_quo_q ? -quo_q : quo_q;
    assign w_rem_fix     = neg_rem_q ? -rem_q : rem_q;
    assign w_dvsr_zero   = (dvsr_q == 32'd0);
    assign w_zero_result = {dend_q, 32'hFFFF_FFFF};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        dend_d    = dend_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        hl_d      = hl_q;
        we_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_RUN;
                    cnt_d     = 6'd0;
                    rem_d     = 32'd0;
                    quo_d     = w_dend_mag;
                    dvsr_d    = w_dvsr_mag;
                    dend_d    = dividend;
                    neg_quo_d = signed_div & (dividend[31] ^ divisor[31]);
                    neg_rem_d = signed_div & dividend[31];
                end
            end
            S_RUN: begin
`ifdef DIV_ZERO_EARLY_EN
                if (w_dvsr_zero) begin
                    state_d = S_DONE;
                    hl_d    = w_zero_result;
                end else begin
                    rem_d = w_rem_step;
                    quo_d = {quo_q[30:0], w_ge};
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_d = S_FIX;
                    end
                end
`else
                rem_d = w_rem_step;
                quo_d = {quo_q[30:0], w_ge};
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d = S_FIX;
                end
`endif
            end
            S_FIX: begin
                hl_d    = w_dvsr_zero ? w_zero_result : {w_rem_fix, w_quo_fix};
                state_d = S_DONE;
            end
            S_DONE: begin
                we_d    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Flush overrides everything, including a start in IDLE and a pending result.
        if (flush) begin
            state_d = S_IDLE;
            we_d    = 1'b0;
            hl_d    = hl_q;
        end

        busy_d = (state_d != S_IDLE) || we_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 6'd0;
            rem_q     <= 32'd0;
            quo_q     <= 32'd0;
            dvsr_q    <= 32'd0;
            dend_q    <= 32'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            we_q      <= 1'b0;
            hl_q      <= 64'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            dend_q    <= dend_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            busy_q    <= busy_d;
            we_q      <= we_d;
            hl_q      <= hl_d;
        end
    end

    assign busy            = busy_q;
    assign hl_write_enable = we_q;
    assign hl_data         = hl_q;

endmodule
`default_nettype wire

// File: doc/div_hilo.md
DIV_HILO -- requirements
Module: div_hilo

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; ports clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a new divide; sampled on rising clk edge.
REQ-005 signed_div  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
REQ-006 dividend  input  32  dividend operand; sampled with start.
REQ-007 divisor  input  32  divisor operand; sampled with start.
REQ-008 flush  input  1  abort any operation in progress (exception or branch flush).
REQ-009 busy  output  1  divide in progress; the pipeline stalls HI/LO readers while high.
REQ-010 hl_write_enable  output  1  one-cycle pulse that writes HI/LO; drives the register file hl_write_enable_from_wb port.
REQ-011 hl_data  output  64  [63:32] = remainder (HI), [31:0] = quotient (LO); valid only while hl_write_enable is high.

Function
REQ-012 SHALL implement the FSM states IDLE, RUN, FIX and DONE; all outputs registered.
REQ-013 IDLE: start=1 and flush=0 latch the operands and signed_div, clear the iteration counter, and go to RUN; start is ignored in every other state.
REQ-014 Signed mode: RUN operates on magnitudes; record quotient sign = sign(dividend) XOR sign(divisor) and remainder sign = sign(dividend).
REQ-015 RUN: one restoring radix-2 step per cycle, exactly 32 cycles, using a 6-bit counter; then go to FIX.
REQ-016 FIX: negate quotient and/or remainder per REQ-014 (signed only), load hl_data, go to DONE.
REQ-017 DONE: hl_write_enable=1 for exactly one cycle, then IDLE.
REQ-018 Latency: with the start edge as edge 0, hl_write_enable is high in the cycle following edge 34.
REQ-019 busy SHALL be high from the cycle after the start edge through the hl_write_enable cycle inclusive, and low in IDLE.
REQ-020 Results: quotient truncates toward zero; remainder takes the sign of the dividend; 0x80000000 / 0xFFFFFFFF signed gives LO=0x80000000 and HI=0.
REQ-021 Divide by zero: LO=0xFFFFFFFF and HI=dividend (raw) in both modes; sign correction is bypassed.
REQ-022 flush in any state: go to IDLE on the next edge; hl_write_enable stays 0; busy drops on that edge.
REQ-023 flush in the same cycle as FIX→DONE: flush wins and no write occurs.
REQ-024 flush and start together in IDLE: start is ignored.
REQ-025 hl_data SHALL hold its last value when not writing; it is 0 after reset.

Reset
REQ-026 rst SHALL force, asynchronously, state=IDLE, busy=0, hl_write_enable=0, hl_data=0, and clear the counter and operand registers.
REQ-027 rst during RUN SHALL produce no write after release; the next start behaves as from power-up.

Configuration
REQ-028 Macro DIV_ZERO_EARLY_EN, when defined: a zero divisor latched at start skips RUN and FIX; DONE is entered on edge 1, so hl_write_enable is high after edge 2 with the REQ-021 values.
REQ-029 Without DIV_ZERO_EARLY_EN: a zero divisor takes the full 34-cycle path and the FIX result is forced to the REQ-021 values.

Verification
REQ-030 Unsigned 100 / 7 -> after edge 34, one write pulse with HI=0x00000002 and LO=0x0000000E; busy high for edges 1..34.
REQ-031 Signed 0xFFFFFFF9 (-7) / 2 -> HI=0xFFFFFFFF and LO=0xFFFFFFFD.
REQ-032 Signed 0x80000000 / 0xFFFFFFFF -> HI=0x00000000 and LO=0x80000000.
REQ-033 flush at edge 10 of a divide -> no hl_write_enable, busy=0 after edge 11; a start at edge 12 completes normally 34 edges later.
REQ-034 Unsigned 5 / 0 -> HI=0x00000005 and LO=0xFFFFFFFF; the pulse comes after edge 2 with DIV_ZERO_EARLY_EN and after edge 34 without it.
REQ-035 rst asserted mid-RUN at edge 20 -> outputs are 0 immediately (asynchronously); no write pulse ever occurs for that operation.
